tdm_demux_8: RTL and testbench

- Receive-side counterpart of the 8:1 select-driven multiplexer: a time-division demultiplexer.
- Takes a 1-bit serial stream carrying 8 channel slots per frame (slot k carries channel k, i.e. the mux input selected when select == k). Reassembles each frame into an 8-bit parallel word.
- Locks to a frame-sync marker, tracks the slot with an internal 3-bit counter, and flags framing errors.
- Sits at the far end of a TDM link, feeding parallel consumers.

---
 rtl/tdm_demux_8.sv | 84 ++++++++
 tb/tb_tdm_demux_8.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_8.sv
// Time-division demultiplexer: locks to a frame-sync marker on a 1-bit serial
// stream and reassembles each 8-slot frame into a parallel word (q[k] = slot k).
module tdm_demux_8 #(
    parameter bit STRICT_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       en,
    input  logic       sync,
    output logic [7:0] q,
    output logic       q_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       frame_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    // Slot 7 never needs storage: it goes straight into q on completion.
    logic [6:0] shadow;

    // locked is a pure decode of the single state flop, so it is glitch-free.
    assign locked = (state == RUN);

    // NOTE: every register here uses non-blocking assignment so all updates
    // within one edge see the pre-edge values of slot/shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            slot      <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Pulses default low; each branch below raises at most one of them.
            q_valid   <= 1'b0;
            frame_err <= 1'b0;

            if (en) begin
                unique case (state)
                    IDLE: begin
                        if (sync) begin
                            shadow <= {6'b0, din};
                            slot   <= 3'd1;
                            state  <= RUN;
                        end
                    end

                    RUN: begin
                        if (sync && (slot != 3'd0)) begin
                            // Misplaced marker: drop the partial frame and
                            // treat this beat as slot 0 of a new frame.
                            frame_err <= 1'b1;
                            shadow    <= {6'b0, din};
                            slot      <= 3'd1;
                        end else if (STRICT_SYNC && !sync && (slot == 3'd0)) begin
                            frame_err <= 1'b1;
                            shadow    <= '0;
                            slot      <= 3'd0;
                            state     <= IDLE;
                        end else if (slot == 3'd7) begin
                            q       <= {din, shadow};
                            q_valid <= 1'b1;
                            shadow  <= '0;
                            slot    <= 3'd0;
                        end else begin
                            shadow[slot] <= din;
                            slot         <= slot + 3'd1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_8.sv
// Scoreboard bench for tdm_demux_8: runs strict and flywheel instances side by
// side; stimulus pushes expected q_valid/frame_err events, monitors pop them.
module tb_tdm_demux_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;

    logic [7:0] q1, q0;
    logic       qv1, qv0, fe1, fe0, lk1, lk0;
    logic [2:0] slot1, slot0;

    typedef struct {
        bit         err;
        logic [7:0] q;
        int         cyc;
    } exp_t;

    exp_t sb1[$];
    exp_t sb0[$];

    int   cycle = 0;
    int   n_checks = 0;
    int   n_err = 0;
    logic rst_seen = 1'b1;
    logic [7:0] last_q1 = 8'h00;
    logic [7:0] last_q0 = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle    <= cycle + 1;
        rst_seen <= rst;
    end

    tdm_demux_8 #(.STRICT_SYNC(1'b1)) dut_strict (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .q(q1), .q_valid(qv1), .slot(slot1), .locked(lk1), .frame_err(fe1)
    );

    tdm_demux_8 #(.STRICT_SYNC(1'b0)) dut_fly (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .q(q0), .q_valid(qv0), .slot(slot0), .locked(lk0), .frame_err(fe0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected event is visible on the cycle stamp taken just after the edge.
    task automatic push(input int id, input bit err, input logic [7:0] v);
        exp_t e;
        e.err = err;
        e.q   = v;
        e.cyc = cycle;
        if (id == 1) sb1.push_back(e);
        else         sb0.push_back(e);
    endtask

    task automatic mon(input int id, input logic v, input logic e, input logic [7:0] qd);
        exp_t x;
        bit   have;
        if (v && e) begin
            n_checks++;
            n_err++;
            $display("FAIL dut%0d overlap: q_valid=1 and frame_err=1 at cycle %0d, required exclusive", id, cycle);
        end else if (v || e) begin
            n_checks++;
            have = 1'b0;
            if (id == 1 && sb1.size() > 0) begin
                x = sb1.pop_front();
                have = 1'b1;
            end else if (id == 0 && sb0.size() > 0) begin
                x = sb0.pop_front();
                have = 1'b1;
            end
            if (!have) begin
                n_err++;
                $display("FAIL dut%0d unexpected: %s q=%0h at cycle %0d, required no event",
                         id, e ? "frame_err" : "q_valid", qd, cycle);
            end else if (x.err != e || x.cyc != cycle || (!e && x.q !== qd)) begin
                n_err++;
                $display("FAIL dut%0d event: got %s q=%0h cycle %0d, required %s q=%0h cycle %0d",
                         id, e ? "frame_err" : "q_valid", qd, cycle,
                         x.err ? "frame_err" : "q_valid", x.q, x.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1, qv1, fe1, q1);
        mon(0, qv0, fe0, q0);
        if (!rst_seen) begin
            check("dut1 q hold", {31'b0, (q1 !== last_q1) && !qv1}, 0);
            check("dut0 q hold", {31'b0, (q0 !== last_q0) && !qv0}, 0);
        end
        last_q1 = q1;
        last_q0 = q0;
    end

    // Drive beats k0..nb-1 of word v; sync on slot 0 when s is set. errm/vm
    // select which instance (bit1 strict, bit0 flywheel) expects an error on
    // the first beat or a q_valid after beat 7.
    task automatic send_frame(input logic [7:0] v, input logic s, input int k0, input int nb,
                              input logic [1:0] errm, input logic [1:0] vm,
                              input int gap_after, input int gap_len);
        logic [2:0] nxt;
        for (int k = k0; k < nb; k++) begin
            din  = v[k];
            sync = s && (k == 0);
            en   = 1'b1;
            @(posedge clk);
            #1;
            if (k == k0) begin
                if (errm[1]) push(1, 1'b1, 8'h00);
                if (errm[0]) push(0, 1'b1, 8'h00);
            end
            if (k == gap_after) begin
                en   = 1'b0;
                sync = 1'b0;
                nxt  = 3'(k + 1);
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                    check("gap slot", {29'b0, slot1}, {29'b0, nxt});
                end
            end
        end
        en   = 1'b0;
        sync = 1'b0;
        if (nb == 8) begin
            if (vm[1]) push(1, 1'b0, v);
            if (vm[0]) push(0, 1'b0, v);
        end
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset q", {24'b0, q1}, 0);
        check("reset q_valid", {31'b0, qv1}, 0);
        check("reset slot", {29'b0, slot1}, 0);
        check("reset locked", {31'b0, lk1}, 0);
        check("reset frame_err", {31'b0, fe1}, 0);

        // Basic frame, locked after the first beat
        send_frame(8'hA5, 1'b1, 0, 1, 2'b00, 2'b00, -1, 0);
        check("locked after sync", {31'b0, lk1}, 1);
        send_frame(8'hA5, 1'b1, 1, 8, 2'b00, 2'b11, -1, 0);
        check("slot wraps", {29'b0, slot1}, 0);
        idle(2);
        check("q A5 held", {24'b0, q1}, 32'hA5);

        // Back-to-back frames, no bubble
        send_frame(8'h3C, 1'b1, 0, 8, 2'b00, 2'b11, -1, 0);
        send_frame(8'hC3, 1'b1, 0, 8, 2'b00, 2'b11, -1, 0);
        idle(2);

        // en gap between slots 2 and 3
        send_frame(8'hF0, 1'b1, 0, 8, 2'b00, 2'b11, 2, 3);
        idle(2);
        check("q F0", {24'b0, q0}, 32'hF0);

        // Misplaced sync at slot 5, resync beat starts frame 81
        send_frame(8'h77, 1'b1, 0, 5, 2'b00, 2'b00, -1, 0);
        check("slot before misplaced sync", {29'b0, slot1}, 5);
        send_frame(8'h81, 1'b1, 0, 8, 2'b11, 2'b11, -1, 0);
        idle(2);

        // Missing sync: strict drops lock, flywheel accepts the frame
        send_frame(8'h66, 1'b0, 0, 8, 2'b10, 2'b01, -1, 0);
        check("strict locked", {31'b0, lk1}, 0);
        check("strict slot", {29'b0, slot1}, 0);
        check("strict q kept", {24'b0, q1}, 32'h81);
        check("fly locked", {31'b0, lk0}, 1);
        check("fly q", {24'b0, q0}, 32'h66);
        send_frame(8'h99, 1'b1, 0, 8, 2'b00, 2'b11, -1, 0);
        idle(2);

        // Reset mid-frame at slot 4
        send_frame(8'hFF, 1'b1, 0, 4, 2'b00, 2'b00, -1, 0);
        check("slot before rst", {29'b0, slot1}, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst q", {24'b0, q1}, 0);
        check("rst slot", {29'b0, slot1}, 0);
        check("rst locked", {31'b0, lk1}, 0);
        check("rst q_valid", {31'b0, qv1}, 0);
        check("rst frame_err", {31'b0, fe1}, 0);
        check("rst fly q", {24'b0, q0}, 0);
        idle(1);
        send_frame(8'h5A, 1'b1, 0, 8, 2'b00, 2'b11, -1, 0);
        idle(3);
        check("q 5A", {24'b0, q1}, 32'h5A);

        check("dut1 scoreboard drained", sb1.size(), 0);
        check("dut0 scoreboard drained", sb0.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
